// File: rtl/rc4_pkg.sv
// RC4 engine shared definitions: FSM state type and
// S-box / key-schedule sizing constants.
package rc4_pkg;

  localparam int SBOX_SIZE = 256;
  localparam int KS_CYCLES = 512;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_RD,
    ST_SWAP,
    ST_KS,
    ST_WR,
    ST_DONE,
    ST_ERR
  } rc4_state_e;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation state: 256x8 registers, two async
// read ports, one-cycle swap port and an init write port.
//   i_wr_*   : init write (priority over swap)
//   i_swap_* : exchange S[a] and S[b] on the clock edge
//   i_ra/rb  : combinational read ports
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_swap_en,
  input  logic [7:0] i_swap_a,
  input  logic [7:0] i_swap_b,
  input  logic [7:0] i_ra_addr,
  output logic [7:0] o_ra_data,
  input  logic [7:0] i_rb_addr,
  output logic [7:0] o_rb_data
);

  logic [7:0] r_s [0:SBOX_SIZE-1];

  assign o_ra_data = r_s[i_ra_addr];
  assign o_rb_data = r_s[i_rb_addr];

  // Contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_s[i_wr_addr] <= i_wr_data;
    end else if (i_swap_en) begin
      r_s[i_swap_a] <= r_s[i_swap_b];
      r_s[i_swap_b] <= r_s[i_swap_a];
    end
  end

endmodule

// File: rtl/rc4_engine.sv
// RC4 decrypt responder: key schedule, then in-place XOR
// of the image buffer over a req/ack byte port.
//   RC4_start/key_len/num_bytes : MCU request
//   key_idx/key_byte            : key lookup
//   mem_*                       : image buffer port
//   RC4_done/error              : held status
module rc4_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 16,
  parameter int ADDR_W    = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         RC4_start,
  input  logic [7:0]                   key_len,
  input  logic [ADDR_W-1:0]            num_bytes,
  output logic [$clog2(KEY_BYTES)-1:0] key_idx,
  input  logic [7:0]                   key_byte,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  input  logic                         mem_ack,
  output logic                         RC4_done,
  output logic                         error
);

  localparam int KW = $clog2(KEY_BYTES);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    KMAX  = 8'(KEY_BYTES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  rc4_state_e        r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [7:0]        r_t;
  logic [7:0]        r_data;
  logic [7:0]        r_wdata;
  logic [7:0]        r_klen;
  logic [KW-1:0]     r_k;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_nbytes;
  logic [TW-1:0]     r_tmo;

  logic [7:0] w_i_nxt;
  logic [7:0] w_ra_addr;
  logic [7:0] w_ra_data;
  logic [7:0] w_rb_data;
  logic [7:0] w_ksa_j;
  logic [7:0] w_swp_j;
  logic [7:0] w_swap_b;
  logic       w_swap_en;
  logic       w_init_en;
  logic       w_k_wrap;
  logic       w_tmo;
  logic       w_last;

  assign w_i_nxt = r_i + 8'd1;

  // Port A: S[i] in INIT/KSA, S[i+1] in SWAP,
  // S[S[i]+S[j]] in KS (sum captured during SWAP).
  always_comb begin
    w_ra_addr = r_i;
    unique case (r_state)
      ST_SWAP: w_ra_addr = w_i_nxt;
      ST_KS:   w_ra_addr = r_t;
      default: w_ra_addr = r_i;
    endcase
  end

  assign w_ksa_j   = r_j + w_ra_data + key_byte;
  assign w_swp_j   = r_j + w_ra_data;
  assign w_swap_b  = (r_state == ST_KSA) ? w_ksa_j : w_swp_j;
  assign w_swap_en = RC4_start &&
                     (r_state == ST_KSA || r_state == ST_SWAP);
  assign w_init_en = RC4_start && (r_state == ST_INIT);
  assign w_k_wrap  = (8'(r_k) == r_klen - 8'd1);
  assign w_tmo     = (r_tmo == TLAST);
  assign w_last    = (r_addr == r_nbytes - 1'b1);

  rc4_sbox u_sbox (
    .clk       (clk),
    .i_wr_en   (w_init_en),
    .i_wr_addr (r_i),
    .i_wr_data (r_i),
    .i_swap_en (w_swap_en),
    .i_swap_a  (w_ra_addr),
    .i_swap_b  (w_swap_b),
    .i_ra_addr (w_ra_addr),
    .o_ra_data (w_ra_data),
    .i_rb_addr (w_swp_j),
    .o_rb_data (w_rb_data)
  );

  assign key_idx   = r_k;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rd    = (r_state == ST_RD);
  assign mem_wr    = (r_state == ST_WR);
  assign RC4_done  = (r_state == ST_DONE);
  assign error     = (r_state == ST_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_t      <= '0;
      r_data   <= '0;
      r_wdata  <= '0;
      r_klen   <= '0;
      r_k      <= '0;
      r_addr   <= '0;
      r_nbytes <= '0;
      r_tmo    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (RC4_start) begin
            r_klen   <= key_len;
            r_nbytes <= num_bytes;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_addr   <= '0;
            r_state  <= (key_len == 8'd0 || key_len > KMAX)
                        ? ST_ERR : ST_INIT;
          end
        end
        ST_INIT: begin
          if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_i <= w_i_nxt;
            if (r_i == 8'hFF) r_state <= ST_KSA;
          end
        end
        ST_KSA: begin
          if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_i <= w_i_nxt;
            r_j <= w_ksa_j;
            r_k <= w_k_wrap ? '0 : r_k + 1'b1;
            if (r_i == 8'hFF) begin
              r_j     <= '0;
              r_tmo   <= '0;
              r_state <= (r_nbytes == '0) ? ST_DONE : ST_RD;
            end
          end
        end
        ST_RD: begin
          // ack beats abort, abort beats timeout
          if (mem_ack) begin
            r_data  <= mem_rdata;
            r_state <= ST_SWAP;
          end else if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_state <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_SWAP: begin
          if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_i     <= w_i_nxt;
            r_j     <= w_swp_j;
            // post-swap S[i]+S[j] equals pre-swap sum
            r_t     <= w_ra_data + w_rb_data;
            r_state <= ST_KS;
          end
        end
        ST_KS: begin
          if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else begin
            r_wdata <= r_data ^ w_ra_data;
            r_tmo   <= '0;
            r_state <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            r_addr  <= r_addr + 1'b1;
            r_tmo   <= '0;
            r_state <= w_last ? ST_DONE : ST_RD;
          end else if (!RC4_start) begin
            r_state <= ST_IDLE;
          end else if (w_tmo) begin
            r_state <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          if (!RC4_start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_engine.sv
// Self-checking bench for rc4_engine: plain-array RC4
// model, req/ack memory responder and per-write checker.
module tb_rc4_engine;

  localparam int KB = 16;
  localparam int AW = 16;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RC4_start = 1'b0;
  logic [7:0]    key_len = '0;
  logic [AW-1:0] num_bytes = '0;
  logic [3:0]    key_idx;
  logic [7:0]    key_byte;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          RC4_done;
  logic          error;

  logic [7:0] key   [0:15];
  logic [7:0] plain [0:255];
  logic [7:0] exp_b [0:255];
  logic [7:0] out_b [0:255];

  logic [7:0] lit_key [0:8] = '{8'hBB, 8'hF3, 8'h16, 8'hE8,
                                8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] lit_wiki [0:4] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};

  int lat = 0;
  bit no_ack = 1'b0;
  int run_id = 0;
  int seen_run = 0;
  int wr_idx = 0;
  int wcnt = 0;
  int c_rd = 0;
  int c_wr = 0;
  int n_chk = 0;
  int n_pass = 0;
  int c_chk = 0;
  int c_pass = 0;

  rc4_engine #(.KEY_BYTES(KB), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .RC4_start (RC4_start),
    .key_len   (key_len),
    .num_bytes (num_bytes),
    .key_idx   (key_idx),
    .key_byte  (key_byte),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .RC4_done  (RC4_done),
    .error     (error)
  );

  always #5 clk = ~clk;

  assign key_byte = key[key_idx];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  task automatic ck(input string nm, input logic [31:0] a,
                    input logic [31:0] e);
    c_chk++;
    if (a === e) c_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  // Memory responder and per-transfer checker.
  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run = run_id;
      wr_idx = 0;
      wcnt = 0;
    end
    if (RC4_done || error)
      ck("status_excl", 32'(RC4_done && error), 0);
    if (!rst && (mem_rd || mem_wr)) begin
      if (mem_rd) c_rd++;
      else c_wr++;
      if (!no_ack && wcnt >= lat) begin
        mem_ack = 1'b1;
        wcnt = 0;
        ck(mem_rd ? "rd_addr" : "wr_addr", 32'(mem_addr), wr_idx);
        if (mem_rd) begin
          mem_rdata = plain[mem_addr[7:0]];
        end else begin
          ck("wr_data", 32'(mem_wdata), 32'(exp_b[wr_idx[7:0]]));
          out_b[mem_addr[7:0]] = mem_wdata;
          wr_idx++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // Textbook RC4 over the bench key/plain arrays.
  function automatic void model(input int klen, input int n);
    int s [0:255];
    int j;
    int i;
    int tmp;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      j = (j + s[x] + int'(key[x % klen])) % 256;
      tmp = s[x]; s[x] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int b = 0; b < n; b++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      exp_b[b] = plain[b] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  task automatic launch(input int klen, input int n);
    @(posedge clk);
    #1;
    key_len = 8'(klen);
    num_bytes = 16'(n);
    run_id++;
    RC4_start = 1'b1;
  endtask

  task automatic wait_status(output int c, input int limit);
    c = 0;
    while (!(RC4_done || error) && c < limit) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic wait_wr(input int limit);
    int w;
    w = 0;
    while (!mem_wr && w < limit) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("wr_seen", 32'(mem_wr), 1);
  endtask

  task automatic finish_run(input logic d, input logic e);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", 32'(RC4_done), 32'(d));
    chk("hold_err", 32'(error), 32'(e));
    RC4_start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", 32'(RC4_done), 0);
    chk("idle_err", 32'(error), 0);
  endtask

  task automatic full_run(input int klen, input int n,
                          input int l);
    int c;
    lat = l;
    model(klen, n);
    launch(klen, n);
    wait_status(c, 3000);
    chk("latency", c, 513 + n * (4 + 2 * l));
    chk("done", 32'(RC4_done), 1);
    chk("err", 32'(error), 0);
    for (int b = 0; b < n; b++)
      chk("buf", 32'(out_b[b]), 32'(exp_b[b]));
    finish_run(1'b1, 1'b0);
  endtask

  task automatic load_key_vec();
    for (int x = 0; x < 16; x++) key[x] = '0;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    plain[0] = 8'h50; plain[1] = 8'h6C; plain[2] = 8'h61;
    plain[3] = 8'h69; plain[4] = 8'h6E; plain[5] = 8'h74;
    plain[6] = 8'h65; plain[7] = 8'h78; plain[8] = 8'h74;
  endtask

  task automatic key_vec_run();
    load_key_vec();
    full_run(3, 9, 0);
    for (int b = 0; b < 9; b++)
      chk("lit_key", 32'(out_b[b]), 32'(lit_key[b]));
  endtask

  initial begin
    int c;
    int rd0;
    int wr0;
    for (int x = 0; x < 256; x++) plain[x] = '0;
    for (int x = 0; x < 16; x++) key[x] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_wr", 32'(mem_wr), 0);
    chk("rst_done", 32'(RC4_done), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_kidx", 32'(key_idx), 0);
    rst = 1'b0;

    key_vec_run();

    key[0] = 8'h57; key[1] = 8'h69; key[2] = 8'h6B; key[3] = 8'h69;
    plain[0] = 8'h70; plain[1] = 8'h65; plain[2] = 8'h64;
    plain[3] = 8'h69; plain[4] = 8'h61;
    full_run(4, 5, 2);
    for (int b = 0; b < 5; b++)
      chk("lit_wiki", 32'(out_b[b]), 32'(lit_wiki[b]));

    lat = 0;
    for (int t = 0; t < 2; t++) begin
      rd0 = c_rd;
      wr0 = c_wr;
      launch(t == 0 ? 0 : KB + 1, 5);
      wait_status(c, 50);
      chk("badlen_lat", c, 1);
      chk("badlen_err", 32'(error), 1);
      chk("badlen_done", 32'(RC4_done), 0);
      finish_run(1'b0, 1'b1);
      chk("badlen_noreq", c_rd + c_wr, rd0 + wr0);
    end

    load_key_vec();
    rd0 = c_rd;
    wr0 = c_wr;
    launch(3, 0);
    wait_status(c, 2000);
    chk("zero_lat", c, 513);
    chk("zero_done", 32'(RC4_done), 1);
    finish_run(1'b1, 1'b0);
    chk("zero_noreq", c_rd + c_wr, rd0 + wr0);

    no_ack = 1'b1;
    model(3, 4);
    rd0 = c_rd;
    launch(3, 4);
    wait_status(c, 2000);
    chk("tmo_lat", c, 513 + TO);
    chk("tmo_err", 32'(error), 1);
    chk("tmo_rd_drop", 32'(mem_rd), 0);
    chk("tmo_rd_cycles", c_rd - rd0, TO);
    no_ack = 1'b0;
    finish_run(1'b0, 1'b1);

    model(3, 9);
    launch(3, 9);
    repeat (300) @(posedge clk);
    #1;
    RC4_start = 1'b0;
    @(posedge clk);
    #1;
    rd0 = c_rd;
    repeat (600) @(posedge clk);
    #1;
    chk("ksa_abort_noreq", c_rd, rd0);
    chk("ksa_abort_done", 32'(RC4_done), 0);
    chk("ksa_abort_err", 32'(error), 0);

    lat = 3;
    launch(3, 9);
    wait_wr(3000);
    RC4_start = 1'b0;
    @(posedge clk);
    #1;
    chk("wr_abort_drop", 32'(mem_wr), 0);
    wr0 = c_wr;
    repeat (50) @(posedge clk);
    #1;
    chk("wr_abort_nowr", c_wr, wr0);
    chk("wr_abort_done", 32'(RC4_done), 0);
    chk("wr_abort_err", 32'(error), 0);
    key_vec_run();

    lat = 1;
    model(3, 9);
    launch(3, 9);
    wait_wr(3000);
    rst = 1'b1;
    #1;
    chk("rstwr_wr", 32'(mem_wr), 0);
    chk("rstwr_rd", 32'(mem_rd), 0);
    chk("rstwr_done", 32'(RC4_done), 0);
    chk("rstwr_err", 32'(error), 0);
    chk("rstwr_addr", 32'(mem_addr), 0);
    chk("rstwr_wdata", 32'(mem_wdata), 0);
    chk("rstwr_kidx", 32'(key_idx), 0);
    rst = 1'b0;
    RC4_start = 1'b0;
    key_vec_run();

    for (int r = 0; r < 6; r++) begin
      int kl;
      int n;
      kl = int'($urandom_range(1, KB));
      n = int'($urandom_range(1, 24));
      for (int x = 0; x < 16; x++) key[x] = 8'($urandom);
      for (int x = 0; x < n; x++) plain[x] = 8'($urandom);
      full_run(kl, n, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass + c_pass,
             n_chk + c_chk);
    $finish;
  end

endmodule

// File: doc/rc4_engine.md
# rc4_engine

Responder side of the MCU decrypt handshake. It waits for `RC4_start` from the MCU and then runs RC4 key scheduling. After that it decrypts the image buffer in place through a request/acknowledge byte-memory port. It reports completion on `RC4_done` or failure on `error`, and holds that status until the MCU drops `RC4_start`.

## Interface
Parameters:
- KEY_BYTES, 16, maximum key length in bytes.
- ADDR_W, 16, image buffer address width.
- TIMEOUT, 255, maximum cycles to wait for `mem_ack` before flagging an error.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- RC4_start  in  1  level request from the MCU; the block starts on it in IDLE, and it must stay high for the whole operation.
- key_len  in  8  key length; legal range 1..KEY_BYTES; sampled when the block leaves IDLE.
- num_bytes  in  ADDR_W  number of image bytes; sampled when the block leaves IDLE.
- key_idx  out  $clog2(KEY_BYTES)  index of the key byte being requested.
- key_byte  in  8  key byte at `key_idx`; combinational lookup, valid in the same cycle.
- mem_addr  out  ADDR_W  image byte address.
- mem_rd  out  1  read request; held until acknowledged.
- mem_wr  out  1  write request; held until acknowledged.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  read data; valid in the cycle `mem_ack` is high.
- mem_ack  in  1  request acknowledge; may be high in the same cycle as the request.
- RC4_done  out  1  success status, held high in DONE.
- error  out  1  failure status, held high in ERR.

## Operation
States: IDLE, INIT, KSA, RD, SWAP, KS, WR, DONE, ERR.
- **IDLE**
  - When `RC4_start` is high, `key_len` and `num_bytes` are latched.
  - If `key_len` is 0 or greater than KEY_BYTES, the next state is ERR.
  - Otherwise the next state is INIT, and i, j, k, addr are cleared.
- **INIT**
  - S[i] = i, one entry per cycle, 256 cycles.
  - After i = 255 the next state is KSA with i = 0.
- **KSA**, one iteration per cycle, 256 cycles:
  - j' = j + S[i] + key_byte, where `key_idx` = k.
  - Swap S[i] and S[j'].
  - k wraps to 0 at key_len-1.
  - After i = 255, i and j are cleared. If num_bytes = 0 the next state is DONE, otherwise RD.
- **RD**
  - `mem_rd` is high with `mem_addr` = addr.
  - On `mem_ack`, data is captured and the next state is SWAP.
- **SWAP**
  - i' = i+1, j' = j + S[i'].
  - Swap S[i'] and S[j'].
- **KS**
  - Keystream K = S[(S[i] + S[j]) mod 256], read from the post-swap array.
  - `mem_wdata` = data XOR K is registered.
- **WR**
  - `mem_wr` is high with the same addr.
  - On `mem_ack`, addr increments. If addr = num_bytes-1, the next state is DONE, otherwise RD.
- **DONE and ERR**
  - The status output stays high while `RC4_start` is high.
  - When `RC4_start` is low, the next state is IDLE.

Arithmetic and boundary rules:
- All i/j/S arithmetic is 8-bit and wraps modulo 256.
- addr is ADDR_W bits wide.
- Timeout: a counter runs in RD and WR and is cleared on each new request. If it reaches TIMEOUT without `mem_ack`, the next state is ERR and the request drops.
- Abort: if `RC4_start` goes low in INIT, KSA, RD, SWAP, KS or WR, the next state is IDLE. No status is raised and requests drop in that same edge.
- Priority in RD and WR: `mem_ack` has priority over abort, and abort has priority over timeout.
- Reset mid-operation: all outputs go low immediately and the state becomes IDLE. The S contents are don't-care.

## Timing
- Reset values: `RC4_done`, `error`, `mem_rd`, `mem_wr` are 0; `mem_addr`, `mem_wdata`, `key_idx` are 0.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Latency:
  - IDLE sampling start at edge t puts the block in INIT from t+1.
  - With zero-wait ack, DONE is entered at edge t+1+512+4·num_bytes.
  - Each ack wait cycle adds one cycle.
- `RC4_done` and `error` are never high together.

## Structure
- `rc4_pkg` holds:
  - the state enum type;
  - the constant SBOX_SIZE = 256;
  - the constant KS_CYCLES = 512.
- Sub-module `rc4_sbox`:
  - 256×8 register array;
  - two asynchronous read ports;
  - one-cycle swap port (swap_en, a, b);
  - INIT write port.
- `rc4_engine` holds the FSM, counters, timeout and memory handshake.

## Test plan
- Key "Key" (4B 65 79), buffer "Plaintext" -> buffer becomes BB F3 16 E8 D9 40 AF 0A D3; `RC4_done` high at cycle 1+512+36 after start.
- Key "Wiki", buffer "pedia" with 2-cycle ack latency -> 10 21 BF 04 20; `RC4_done` held until `RC4_start` falls, then IDLE.
- key_len = 0, then key_len = KEY_BYTES+1 -> `error` high one cycle after start and no memory requests; num_bytes = 0 -> DONE after 513 cycles and no requests.
- `mem_ack` never asserted in the first RD -> `error` after TIMEOUT cycles and `mem_rd` drops in the same edge.
- `RC4_start` dropped in KSA and again in WR -> IDLE next cycle, no status and no further writes; rerun with the "Key" vector and the correct result returns.
- `rst` pulsed in WR -> outputs 0 immediately; the following full run decrypts correctly.
